// File: rtl/oled_pkg.sv
// oled_pkg: shared state encoding, ASCII constants and default message for the OLED text sequencer
package oled_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
    localparam logic [7:0] H = 8'h68;
    localparam logic [7:0] E = 8'h65;
    localparam logic [7:0] L = 8'h6C;
    localparam logic [7:0] O = 8'h6F;
    localparam int DEFAULT_MAX_LEN = 16;
    // entry 0 sits in the least significant byte
    localparam logic [DEFAULT_MAX_LEN*8-1:0] DEFAULT_MSG = {{((DEFAULT_MAX_LEN-5)*8){1'b0}}, O, L, L, E, H};
endpackage

// File: rtl/oled_text_sequencer_if.sv
// oled_text_sequencer_if: byte interface towards the oled_controller
interface oled_text_sequencer_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] data_out;
    logic write_enable;
    logic buffer_full;
    modport master(output data_out, write_enable, input buffer_full);
    modport slave(input data_out, write_enable, output buffer_full);
endinterface

// File: rtl/oled_msg_store.sv
// oled_msg_store: message register array, sync write gated by busy, async read
module oled_msg_store import oled_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int MAX_LEN = 16,
    parameter int AW = $clog2(MAX_LEN),
    parameter logic [MAX_LEN*DATA_W-1:0] INIT_MSG = (MAX_LEN*DATA_W)'(DEFAULT_MSG)
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) mem[i] <= INIT_MSG[i*DATA_W +: DATA_W];
        end else if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/oled_text_sequencer.sv
// oled_text_sequencer: streams a programmable byte string into the oled_controller byte interface
module oled_text_sequencer import oled_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int MAX_LEN = 16,
    parameter int GAP_CYCLES = 0,
    parameter logic [MAX_LEN*DATA_W-1:0] INIT_MSG = (MAX_LEN*DATA_W)'(DEFAULT_MSG),
    parameter int INIT_LEN = 5,
    localparam int AW = $clog2(MAX_LEN),
    localparam int LW = $clog2(MAX_LEN+1)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic abort,
    input  logic repeat_en,
    input  logic msg_wr_en,
    input  logic [AW-1:0] msg_wr_addr,
    input  logic [DATA_W-1:0] msg_wr_data,
    input  logic len_wr_en,
    input  logic [LW-1:0] len_wr_data,
    oled_text_sequencer_if.master bus,
    output logic busy,
    output logic done
);
    localparam int GW = $clog2(GAP_CYCLES+2);

    state_t state;
    logic [AW-1:0] idx;
    logic [LW-1:0] len;
    logic [GW-1:0] cnt;
    logic [DATA_W-1:0] rd_data;
    logic last;

    oled_msg_store #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .INIT_MSG(INIT_MSG)) store (
        .clk, .reset, .busy,
        .wr_en(msg_wr_en), .wr_addr(msg_wr_addr), .wr_data(msg_wr_data),
        .rd_addr(idx), .rd_data
    );

    assign last = LW'(idx) + LW'(1) >= len;

    always_ff @(posedge clk) begin
        if (reset) begin
            len <= LW'(INIT_LEN);
        end else if (len_wr_en && !busy) begin
            len <= len_wr_data > LW'(MAX_LEN) ? LW'(MAX_LEN) : len_wr_data;
        end
    end

    // the write cycle itself is the first GAP cycle, so SEND never follows a write directly
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            bus.data_out <= '0;
            bus.write_enable <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            bus.write_enable <= 1'b0;
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: if (start) begin
                        idx <= '0;
                        cnt <= '0;
                        state <= len == '0 ? DONE : SEND;
                        done <= len == '0;
                        busy <= len != '0;
                    end
                    SEND: if (!bus.buffer_full) begin
                        bus.write_enable <= 1'b1;
                        bus.data_out <= rd_data;
                        cnt <= '0;
                        state <= GAP;
                    end
                    GAP: if (cnt == GW'(GAP_CYCLES)) begin
                        cnt <= '0;
                        done <= last;
                        idx <= last ? '0 : idx + AW'(1);
                        state <= last && !repeat_en ? DONE : SEND;
                        busy <= !last || repeat_en;
                    end else begin
                        cnt <= cnt + GW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_oled_text_sequencer.sv
// tb_oled_text_sequencer: scoreboard bench with a GAP_CYCLES=0 and a GAP_CYCLES=3 instance
module tb_oled_text_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, abort = 1'b0, repeat_en = 1'b0;
    logic msg_wr_en = 1'b0, len_wr_en = 1'b0;
    logic [3:0] msg_wr_addr = '0;
    logic [7:0] msg_wr_data = '0;
    logic [4:0] len_wr_data = '0;
    logic busy0, done0, busy1, done1;

    always #5 clk = ~clk;

    oled_text_sequencer_if #(.DATA_W(8)) if0();
    oled_text_sequencer_if #(.DATA_W(8)) if1();

    oled_text_sequencer #(.GAP_CYCLES(0)) u0 (
        .clk, .reset, .start(start0), .abort, .repeat_en,
        .msg_wr_en, .msg_wr_addr, .msg_wr_data, .len_wr_en, .len_wr_data,
        .bus(if0), .busy(busy0), .done(done0)
    );

    oled_text_sequencer #(.GAP_CYCLES(3)) u1 (
        .clk, .reset, .start(start1), .abort, .repeat_en,
        .msg_wr_en, .msg_wr_addr, .msg_wr_data, .len_wr_en, .len_wr_data,
        .bus(if1), .busy(busy1), .done(done1)
    );

    typedef struct {logic [7:0] d; int c;} exp_t;
    exp_t wq0[$], wq1[$];
    int dq0[$], dq1[$];
    exp_t e0, e1;
    int d0, d1;
    int cyc = 0;
    int checks = 0, passed = 0;
    logic [7:0] hello [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(int c);
        while (cyc < c) tick();
    endtask

    // monitors: every write_enable/done pulse must match the head of its queue
    always @(negedge clk) begin
        if (if0.write_enable) begin
            if (wq0.size() == 0) chk("u0 extra write queue", 0, 1);
            else begin
                e0 = wq0.pop_front();
                chk("u0 data", int'(if0.data_out), int'(e0.d));
                chk("u0 write cycle", cyc, e0.c);
            end
        end
        if (done0) begin
            if (dq0.size() == 0) chk("u0 extra done queue", 0, 1);
            else begin
                d0 = dq0.pop_front();
                chk("u0 done cycle", cyc, d0);
            end
        end
        if (if1.write_enable) begin
            if (wq1.size() == 0) chk("u1 extra write queue", 0, 1);
            else begin
                e1 = wq1.pop_front();
                chk("u1 data", int'(if1.data_out), int'(e1.d));
                chk("u1 write cycle", cyc, e1.c);
            end
        end
        if (done1) begin
            if (dq1.size() == 0) chk("u1 extra done queue", 0, 1);
            else begin
                d1 = dq1.pop_front();
                chk("u1 done cycle", cyc, d1);
            end
        end
    end

    initial begin
        int t;
        if0.buffer_full = 1'b0;
        if1.buffer_full = 1'b0;
        tick(2);
        chk("reset write_enable", int'(if0.write_enable), 0);
        chk("reset data_out", int'(if0.data_out), 0);
        chk("reset busy", int'(busy0), 0);
        chk("reset done", int'(done0), 0);
        reset = 1'b0;
        tick();

        // default hello, back-to-back
        t = cyc;
        start0 = 1'b1;
        for (int k = 0; k < 5; k++) wq0.push_back('{hello[k], t + 2 + 2*k});
        dq0.push_back(t + 11);
        tick();
        start0 = 1'b0;
        wait_to(t + 3);
        chk("data_out hold", int'(if0.data_out), 8'h68);
        chk("busy mid-message", int'(busy0), 1);
        wait_to(t + 14);
        chk("busy after hello", int'(busy0), 0);

        // backpressure for cycles t..t+6
        t = cyc;
        start0 = 1'b1;
        if0.buffer_full = 1'b1;
        for (int k = 0; k < 5; k++) wq0.push_back('{hello[k], t + 8 + 2*k});
        dq0.push_back(t + 17);
        tick();
        start0 = 1'b0;
        wait_to(t + 7);
        if0.buffer_full = 1'b0;
        wait_to(t + 20);

        // "AB" repeat on the GAP_CYCLES=3 instance
        msg_wr_en = 1'b1; msg_wr_addr = 4'd0; msg_wr_data = 8'h41;
        tick();
        msg_wr_addr = 4'd1; msg_wr_data = 8'h42;
        tick();
        msg_wr_en = 1'b0; len_wr_en = 1'b1; len_wr_data = 5'd2;
        tick();
        len_wr_en = 1'b0;
        repeat_en = 1'b1;
        t = cyc;
        start1 = 1'b1;
        for (int k = 0; k < 6; k++) wq1.push_back('{(k % 2) ? 8'h42 : 8'h41, t + 2 + 5*k});
        dq1.push_back(t + 11); dq1.push_back(t + 21); dq1.push_back(t + 31);
        tick();
        start1 = 1'b0;
        wait_to(t + 23);
        repeat_en = 1'b0;
        wait_to(t + 34);
        chk("u1 busy after repeat", int'(busy1), 0);

        // abort after the second byte
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        t = cyc;
        start0 = 1'b1;
        wq0.push_back('{8'h68, t + 2});
        wq0.push_back('{8'h65, t + 4});
        tick();
        start0 = 1'b0;
        wait_to(t + 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort write_enable", int'(if0.write_enable), 0);
        chk("abort busy", int'(busy0), 0);
        wait_to(t + 10);
        t = cyc;
        start0 = 1'b1;
        for (int k = 0; k < 5; k++) wq0.push_back('{hello[k], t + 2 + 2*k});
        dq0.push_back(t + 11);
        tick();
        start0 = 1'b0;
        wait_to(t + 14);

        // length clamp to 16, store write while busy dropped
        len_wr_en = 1'b1; len_wr_data = 5'd20;
        tick();
        len_wr_en = 1'b0;
        t = cyc;
        start0 = 1'b1;
        for (int k = 0; k < 16; k++) wq0.push_back('{(k < 5) ? hello[k] : 8'h00, t + 2 + 2*k});
        dq0.push_back(t + 33);
        tick();
        start0 = 1'b0;
        wait_to(t + 10);
        msg_wr_en = 1'b1; msg_wr_addr = 4'd15; msg_wr_data = 8'hEE;
        tick();
        msg_wr_en = 1'b0;
        wait_to(t + 36);

        // zero length
        len_wr_en = 1'b1; len_wr_data = 5'd0;
        tick();
        len_wr_en = 1'b0;
        t = cyc;
        start0 = 1'b1;
        dq0.push_back(t + 1);
        tick();
        start0 = 1'b0;
        wait_to(t + 4);
        chk("zero length busy", int'(busy0), 0);

        // reset mid-message restores the store
        msg_wr_en = 1'b1; msg_wr_addr = 4'd0; msg_wr_data = 8'h58;
        len_wr_en = 1'b1; len_wr_data = 5'd5;
        tick();
        msg_wr_en = 1'b0; len_wr_en = 1'b0;
        t = cyc;
        start0 = 1'b1;
        wq0.push_back('{8'h58, t + 2});
        wq0.push_back('{8'h65, t + 4});
        tick();
        start0 = 1'b0;
        wait_to(t + 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid reset write_enable", int'(if0.write_enable), 0);
        chk("mid reset data_out", int'(if0.data_out), 0);
        chk("mid reset busy", int'(busy0), 0);
        chk("mid reset done", int'(done0), 0);
        tick();
        t = cyc;
        start0 = 1'b1;
        for (int k = 0; k < 5; k++) wq0.push_back('{hello[k], t + 2 + 2*k});
        dq0.push_back(t + 11);
        tick();
        start0 = 1'b0;
        wait_to(t + 14);

        chk("u0 writes outstanding", wq0.size(), 0);
        chk("u0 dones outstanding", dq0.size(), 0);
        chk("u1 writes outstanding", wq1.size(), 0);
        chk("u1 dones outstanding", dq1.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/oled_text_sequencer.md
Name: oled_text_sequencer

Overview:
- Parametrised successor to the fixed "hello" sender. Streams a programmable byte string from an internal message store into the oled_controller byte interface (data_in / write_enable / buffer_full).
- Adds a runtime-loadable message, variable length, backpressure on buffer_full, an inter-byte gap, repeat mode, abort, and busy/done status.
- Sits between the tt_um top and oled_controller.

Parameters:
- DATA_W, 8, byte width of the message and the data_out port.
- MAX_LEN, 16, message store depth (entries). Must be 2 or more.
- GAP_CYCLES, 0, idle cycles inserted after each accepted byte. 0 means back-to-back.
- INIT_MSG, "hello" padded to MAX_LEN, reset contents of the store; entry 0 is 'h' (8'h68).
- INIT_LEN, 5, reset value of the length register.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to send the message; ignored unless IDLE or DONE
- abort  in  1  return to IDLE next cycle; no further writes
- repeat_en  in  1  when high at end of message, restart at index 0 instead of stopping
- msg_wr_en  in  1  write one store entry
- msg_wr_addr  in  $clog2(MAX_LEN)  entry address
- msg_wr_data  in  DATA_W  entry data
- len_wr_en  in  1  load the length register
- len_wr_data  in  $clog2(MAX_LEN+1)  new length
- buffer_full  in  1  controller backpressure
- data_out  out  DATA_W  to oled_controller data_in
- write_enable  out  1  to oled_controller write_enable; one-cycle pulse per byte
- busy  out  1  high in SEND or GAP
- done  out  1  one-cycle pulse at the end of each message pass

Behaviour:
- Reset (synchronous): state=IDLE, idx=0, data_out=0, write_enable=0, busy=0, done=0. Store is reloaded with INIT_MSG and length with INIT_LEN.
- Outputs are registered. write_enable is never high for two consecutive cycles.
- Length writes: if len_wr_data > MAX_LEN, store MAX_LEN (clamp).
- Store and length writes are accepted only when busy=0; while busy they are silently dropped.
- States:
  - IDLE: on start with len=0, go to DONE and pulse done at t+1; no writes. On start with len>0, set idx=0 and go to SEND.
  - SEND: if buffer_full=0, the next cycle has write_enable=1 and data_out=mem[idx]; then go to GAP, or (GAP_CYCLES=0) advance directly. If buffer_full=1, hold and assert nothing; no timeout.
  - GAP: count GAP_CYCLES cycles, then advance.
  - Advance: if idx<len-1, idx+=1 and go to SEND. Else pulse done. If repeat_en=1, set idx=0 and go to SEND. Otherwise go to DONE.
  - DONE: holds; start re-launches exactly as from IDLE.
- Latency: start at cycle t with buffer_full low gives the first write_enable at t+2. With GAP_CYCLES=0, a 5-byte message fills cycles t+2, t+4, t+6, t+8, t+10. The extra cycle is from SEND re-evaluating buffer_full.
- data_out holds its last value between pulses.
- Simultaneous events, in priority order:
  - reset beats everything.
  - abort beats start, and forces write_enable=0 on the following cycle.
  - start and abort together: remain or go IDLE.
  - msg_wr_en while idle with start in the same cycle: the write lands, and the send reads the new data.
- repeat_en is sampled only at the advance from the last byte. Dropping it mid-pass finishes the current pass.

Decomposition:
- Shared package oled_pkg holds:
  - state enum {IDLE, SEND, GAP, DONE};
  - ASCII constants (H=8'h68, E=8'h65, L=8'h6C, O=8'h6F);
  - the default INIT_MSG.
- One natural sub-module, oled_msg_store: MAX_LEN x DATA_W register array with a sync write port, an async read port, reset initialisation, and the busy write-gate.

Test Plan:
- Default after reset, start pulse, buffer_full=0, GAP=0 -> write_enable pulses carrying 68,65,6C,6C,6F at t+2, t+4, t+6, t+8, t+10; one done pulse at t+11; busy low afterwards.
- buffer_full held high for 7 cycles from the start cycle -> no write_enable until it drops; sequence and order unchanged; no byte lost or duplicated.
- Load "AB" (41, 42), len=2, repeat_en=1, GAP_CYCLES=3 -> pattern 41,42,41,42,… with 4-cycle byte spacing plus the SEND cycle; done pulses after every 42. Drop repeat_en -> stops after the next 42.
- abort asserted after the second byte -> write_enable=0 from the next cycle; state IDLE; a later start sends from index 0.
- len_wr_data=20 with MAX_LEN=16 -> length reads 16. A store write while busy -> entry unchanged.
- len=0 then start -> no write_enable; done pulses at t+1. reset asserted mid-message -> all outputs 0 the next cycle and store reverts to "hello".
